// File: rtl/vmem_xbar_sched_pkg.sv
// Shared definitions for the vector-memory load crossbar sequencer:
// controller state encoding and line geometry.
package vmem_pkg;

  localparam int unsigned LINE_BITS      = 512;
  localparam int unsigned ELEM_BITS      = 32;
  localparam int unsigned ELEMS_PER_LINE = LINE_BITS / ELEM_BITS;
  localparam int unsigned SEL_W          = $clog2(ELEMS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/vmem_xbar_sched_lane_match.sv
// Per-lane line match: a pending lane whose element lives in the fetched
// line is served now, selecting its element offset within that line.
module vmem_lane_match #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned SELWIDTH  = 4
) (
  input  logic [ADDRWIDTH-1:0]          lane_addr,
  input  logic                          pending,
  input  logic [ADDRWIDTH-SELWIDTH-1:0] cur_line,
  output logic                          match,
  output logic [SELWIDTH-1:0]           sel
);

  always_comb begin
    match = pending && (lane_addr[ADDRWIDTH-1:SELWIDTH] == cur_line);
    sel   = match ? lane_addr[SELWIDTH-1:0] : '0;
  end

endmodule

// File: rtl/vmem_xbar_sched.sv
// Strided vector-load sequencer: fetches one memory line at a time and
// steers every element of that line into its lane through the crossbar.
module vmem_xbar_sched
  import vmem_pkg::*;
#(
  parameter int unsigned NUMOUTS     = 16,
  parameter int unsigned SELWIDTH    = SEL_W,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned STRIDEWIDTH = 16,
  parameter int unsigned VLWIDTH     = 7,
  parameter int unsigned GRPWIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [ADDRWIDTH-1:0]          base,
  input  logic [STRIDEWIDTH-1:0]        stride,
  input  logic [VLWIDTH-1:0]            vl,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req,
  output logic [ADDRWIDTH-SELWIDTH-1:0] mem_line,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  output logic [SELWIDTH*NUMOUTS-1:0]   xbar_sel,
  output logic [NUMOUTS-1:0]            lane_we,
  output logic [GRPWIDTH-1:0]           wb_group
);

  localparam int unsigned LINEW = ADDRWIDTH - SELWIDTH;
  localparam int unsigned CNTW  = VLWIDTH + 1;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   lane_addr_q [NUMOUTS];
  logic [ADDRWIDTH-1:0]   lane_addr_d [NUMOUTS];
  logic [NUMOUTS-1:0]     pending_q, pending_d;
  logic [GRPWIDTH-1:0]    group_q, group_d;
  logic [LINEW-1:0]       cur_line_q, cur_line_d;
  logic [VLWIDTH-1:0]     vl_q, vl_d;
  logic [ADDRWIDTH-1:0]   stride_q, stride_d;

  logic [NUMOUTS-1:0]     match;
  logic [SELWIDTH-1:0]    sel [NUMOUTS];
  logic [ADDRWIDTH-1:0]   stride_ext;
  logic [ADDRWIDTH-1:0]   grp_step;
  logic [LINEW-1:0]       first_line;
  logic                   found;
  logic [CNTW-1:0]        next_base;

  for (genvar gi = 0; gi < NUMOUTS; gi++) begin : g_lane
    vmem_lane_match #(
      .ADDRWIDTH(ADDRWIDTH),
      .SELWIDTH (SELWIDTH)
    ) u_match (
      .lane_addr(lane_addr_q[gi]),
      .pending  (pending_q[gi]),
      .cur_line (cur_line_q),
      .match    (match[gi]),
      .sel      (sel[gi])
    );
  end

  assign stride_ext = ADDRWIDTH'($signed(stride));
  assign grp_step   = stride_q * ADDRWIDTH'(NUMOUTS);
  assign next_base  = CNTW'((32'(group_q) + 32'd1) * NUMOUTS);
  assign wb_group   = group_q;

  // Line of the lowest-index pending lane drives the next request.
  always_comb begin
    first_line = lane_addr_q[0][ADDRWIDTH-1:SELWIDTH];
    found      = 1'b0;
    for (int unsigned i = 0; i < NUMOUTS; i++) begin
      if (pending_q[i] && !found) begin
        first_line = lane_addr_q[i][ADDRWIDTH-1:SELWIDTH];
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_addr_d = lane_addr_q;
    pending_d   = pending_q;
    group_d     = group_q;
    cur_line_d  = cur_line_q;
    vl_d        = vl_q;
    stride_d    = stride_q;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_line    = '0;
    lane_we     = '0;
    xbar_sel    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vl_d      = vl;
          stride_d  = stride_ext;
          group_d   = '0;
          pending_d = '0;
          if (vl != '0) begin
            for (int unsigned i = 0; i < NUMOUTS; i++) begin
              lane_addr_d[i] = base + ADDRWIDTH'(i) * stride_ext;
              pending_d[i]   = (i < 32'(vl));
            end
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        mem_req    = 1'b1;
        mem_line   = first_line;
        cur_line_d = first_line;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        for (int unsigned i = 0; i < NUMOUTS; i++) begin
          xbar_sel[i*SELWIDTH +: SELWIDTH] = sel[i];
        end
        lane_we = {NUMOUTS{mem_rvalid}} & match;
        if (mem_rvalid) begin
          pending_d = pending_q & ~match;
          if (pending_d != '0) begin
            state_d = ST_ISSUE;
          end else if (next_base >= CNTW'(vl_q)) begin
            state_d = ST_FIN;
          end else begin
            group_d = group_q + 1'b1;
            for (int unsigned i = 0; i < NUMOUTS; i++) begin
              lane_addr_d[i] = lane_addr_q[i] + grp_step;
              pending_d[i]   = (32'(next_base) + i < 32'(vl_q));
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      lane_addr_q <= '{default: '0};
      pending_q   <= '0;
      group_q     <= '0;
      cur_line_q  <= '0;
      vl_q        <= '0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      lane_addr_q <= lane_addr_d;
      pending_q   <= pending_d;
      group_q     <= group_d;
      cur_line_q  <= cur_line_d;
      vl_q        <= vl_d;
      stride_q    <= stride_d;
    end
  end

endmodule

// File: tb/tb_vmem_xbar_sched.sv
// Self-checking bench for vmem_xbar_sched: each load is predicted as a list
// of line fetches computed directly from element addresses.
module tb_vmem_xbar_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] base;
  logic [15:0] stride;
  logic [6:0]  vl;
  logic        busy, done, mem_req, mem_gnt, mem_rvalid;
  logic [27:0] mem_line;
  logic [63:0] xbar_sel;
  logic [15:0] lane_we;
  logic [1:0]  wb_group;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [27:0] line;
    logic [15:0] we;
    logic [63:0] sel;
    logic [1:0]  grp;
  } fetch_t;

  always #5 clk = ~clk;

  vmem_xbar_sched #(
    .NUMOUTS(16), .SELWIDTH(4), .ADDRWIDTH(32),
    .STRIDEWIDTH(16), .VLWIDTH(7), .GRPWIDTH(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base(base), .stride(stride),
    .vl(vl), .busy(busy), .done(done), .mem_req(mem_req), .mem_line(mem_line),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .xbar_sel(xbar_sel),
    .lane_we(lane_we), .wb_group(wb_group)
  );

  function automatic logic [31:0] eaddr(input logic [31:0] b, input int s, input int e);
    return b + 32'(e * s);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b1; start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
  endtask

  // Predict the fetch sequence, then drive the memory side and check each step.
  task automatic run_load(input logic [31:0] b, input logic [15:0] s,
                          input logic [6:0] v, input bit fixed);
    fetch_t q[$];
    fetch_t f;
    logic [15:0] pend;
    logic [31:0] a;
    int s_int, fl, nwait, fails0;
    bit granted;
    fails0 = miscompares;
    s_int = int'($signed(s));
    for (int g = 0; g * 16 < int'(v); g++) begin
      pend = '0;
      for (int i = 0; i < 16; i++) if (g * 16 + i < int'(v)) pend[i] = 1'b1;
      while (pend != '0) begin
        fl = 0;
        for (int i = 15; i >= 0; i--) if (pend[i]) fl = i;
        a = eaddr(b, s_int, g * 16 + fl);
        f.line = a[31:4]; f.we = '0; f.sel = '0; f.grp = 2'(g);
        for (int i = 0; i < 16; i++) begin
          a = eaddr(b, s_int, g * 16 + i);
          if (pend[i] && a[31:4] == f.line) begin
            f.we[i] = 1'b1;
            f.sel[i*4 +: 4] = a[3:0];
          end
        end
        pend &= ~f.we;
        q.push_back(f);
      end
    end

    @(negedge clk);
    start = 1'b1; base = b; stride = s; vl = v; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    foreach (q[k]) begin
      granted = 1'b0;
      for (int c = 0; c < 8 && !granted; c++) begin
        @(negedge clk);
        start      = fixed ? 1'b0 : 1'($urandom % 2);
        base       = $urandom; vl = 7'($urandom); stride = 16'($urandom);
        mem_gnt    = fixed || c == 7 || ($urandom % 3 == 0);
        mem_rvalid = fixed ? 1'b0 : 1'($urandom % 2);
        granted    = mem_gnt;
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_line !== q[k].line || lane_we !== 16'h0 ||
            done !== 1'b0 || busy !== 1'b1 || wb_group !== q[k].grp) begin
          miscompares++;
          $display("FAIL issue[%0d]: req=%b line=%h we=%h done=%b busy=%b grp=%0d, expected req=1 line=%h we=0 done=0 busy=1 grp=%0d",
                   k, mem_req, mem_line, lane_we, done, busy, wb_group, q[k].line, q[k].grp);
        end
      end
      nwait = fixed ? 0 : int'($urandom % 3);
      for (int c = 0; c < nwait; c++) begin
        @(negedge clk);
        start = 1'($urandom % 2); mem_gnt = 1'($urandom % 2); mem_rvalid = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || lane_we !== 16'h0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL wait[%0d]: req=%b we=%h done=%b, expected 0/0/0", k, mem_req, lane_we, done);
        end
      end
      @(negedge clk);
      start = fixed ? 1'b0 : 1'($urandom % 2); mem_gnt = 1'b0; mem_rvalid = 1'b1;
      #1;
      vectors++;
      if (lane_we !== q[k].we || xbar_sel !== q[k].sel || wb_group !== q[k].grp ||
          mem_req !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL rvalid[%0d]: we=%h sel=%h grp=%0d req=%b done=%b, expected we=%h sel=%h grp=%0d req=0 done=0",
                 k, lane_we, xbar_sel, wb_group, mem_req, done, q[k].we, q[k].sel, q[k].grp);
      end
    end
    @(negedge clk);
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || lane_we !== 16'h0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b we=%h, expected 1/1/0", done, busy, lane_we);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after: done=%b busy=%b req=%b, expected 0/0/0", done, busy, mem_req);
    end
    if (miscompares != fails0) pulse_reset();
  endtask

  task automatic test_reset();
    resetn = 1'b1; start = 1'b1; base = 32'h100; stride = 16'd1; vl = 7'd16;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || lane_we !== 16'h0 ||
        xbar_sel !== 64'h0 || wb_group !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b req=%b we=%h sel=%h grp=%0d, expected all 0",
               busy, done, mem_req, lane_we, xbar_sel, wb_group);
    end
    @(negedge clk);
    resetn = 1'b0; start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_aligned();     run_load(32'h100, 16'd1, 7'd16, 1'b1); endtask
  task automatic test_misaligned();  run_load(32'h104, 16'd1, 7'd16, 1'b0); endtask
  task automatic test_stride0();     run_load(32'h37, 16'd0, 7'd5, 1'b0);   endtask
  task automatic test_multi_group(); run_load(32'h0, 16'd1, 7'd40, 1'b0);   endtask
  task automatic test_neg_stride();  run_load(32'h20, 16'hFFFF, 7'd3, 1'b0); endtask
  task automatic test_vl_zero();     run_load(32'h55, 16'd3, 7'd0, 1'b0);   endtask
  task automatic test_wrap();        run_load(32'hFFFF_FFF8, 16'd1, 7'd64, 1'b0); endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; base = 32'h100; stride = 16'd1; vl = 7'd16; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b0; resetn = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_in_wait: busy=%b, expected 1", busy);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      resetn = 1'b0; mem_rvalid = (c == 0) ? 1'b1 : 1'($urandom % 2);
      #1;
      vectors++;
      if (lane_we !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || xbar_sel !== 64'h0) begin
        miscompares++;
        $display("FAIL stray_rvalid[%0d]: we=%h busy=%b done=%b sel=%h, expected all 0",
                 c, lane_we, busy, done, xbar_sel);
      end
    end
    mem_rvalid = 1'b0;
    run_load(32'h200, 16'd2, 7'd16, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] s;
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 5)
        0: s = 16'd0;
        1: s = 16'd1;
        2: s = 16'hFFFF;
        3: s = 16'($signed($urandom_range(0, 40)) - 20);
        default: s = 16'($urandom);
      endcase
      run_load($urandom, s, 7'($urandom_range(0, 64)), 1'b0);
    end
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; base = '0; stride = '0; vl = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    test_reset();
    test_aligned();
    test_misaligned();
    test_stride0();
    test_multi_group();
    test_neg_stride();
    test_vl_zero();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
